// File: rtl/nv_nvdla_cacc_psum_buf_pkg.sv
// Shared constants and state encoding for the CACC partial-sum buffer.
package nv_nvdla_cacc_psum_buf_pkg;

    localparam int unsigned CACC_DW         = 22;
    localparam int unsigned CACC_PW         = 34;
    localparam int unsigned CACC_MIN_STRIPE = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } psum_state_e;

endpackage

// File: rtl/nv_nvdla_cacc_psum_ram.sv
// Partial-sum storage: DEPTH x DW flop array, one write port and one
// registered read port. The data array carries no reset.
module nv_nvdla_cacc_psum_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6,
    parameter int unsigned DW    = 34
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write at end of cycle; read data registered for one-cycle latency.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/nv_nvdla_cacc_psum_buf.sv
// Partial-sum store and operand sequencer for one CACC accumulation lane.
// Forward path pairs each MAC beat with its stored partial sum; return path
// writes the calculator's partial results back into the buffer.
module nv_nvdla_cacc_psum_buf
    import nv_nvdla_cacc_psum_buf_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
    input  logic [AW:0]         cfg_stripe_len,
    input  logic                mac_valid,
    input  logic [CACC_DW-1:0]  mac_data,
    input  logic                mac_first,
    input  logic                mac_last,
    output logic                calc_in_valid,
    output logic [CACC_DW-1:0]  calc_in_data,
    output logic [CACC_PW-1:0]  calc_in_op,
    output logic                calc_in_op_valid,
    output logic                calc_in_sel,
    input  logic                calc_out_partial_valid,
    input  logic [CACC_PW-1:0]  calc_out_partial_data,
    output logic                busy,
    output logic                err
);

    typedef logic [AW:0] len_t;

    localparam len_t LEN_MIN = len_t'(CACC_MIN_STRIPE);
    localparam len_t LEN_MAX = len_t'(DEPTH);

    psum_state_e        state;
    psum_state_e        state_nxt;
    len_t               len_q;
    len_t               len_cfg;
    len_t               len_cur;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic               first_q;
    logic               last_q;
    logic [1:0]         pend;
    logic               err_q;
    logic               valid_q;
    logic               opv_q;
    logic               sel_q;
    logic [CACC_DW-1:0] data_q;
    logic [CACC_PW-1:0] rd_data;

    logic start;
    logic grp_beat;
    logic issue;
    logic at_zero;
    logic eff_first;
    logic eff_last;
    logic rd_wrap;
    logic wr_wrap;
    logic wr_en;
    logic len_bad;
    logic underflow;
    logic idle_stray;
    logic inc;

    assign len_bad = (cfg_stripe_len < LEN_MIN) || (cfg_stripe_len > LEN_MAX);
    assign len_cfg = (cfg_stripe_len < LEN_MIN) ? LEN_MIN :
                     (cfg_stripe_len > LEN_MAX) ? LEN_MAX : cfg_stripe_len;
    // The group-opening beat must wrap against the length being latched.
    assign len_cur = (state == IDLE) ? len_cfg : len_q;

    assign start      = (state == IDLE) && mac_valid && mac_first;
    assign grp_beat   = mac_valid && ((state == RUN) || start);
    // Stray beats in IDLE are still forwarded, as plain non-accumulating beats.
    assign issue      = mac_valid && (state != DRAIN);
    assign idle_stray = (state == IDLE) && mac_valid && !mac_first;

    // Stripe flags are sampled at element 0; that beat uses the live inputs.
    assign at_zero   = (rd_ptr == '0);
    assign eff_first = at_zero ? mac_first : first_q;
    assign eff_last  = at_zero ? mac_last  : last_q;

    assign rd_wrap = ({1'b0, rd_ptr} == (len_cur - len_t'(1)));
    assign wr_wrap = ({1'b0, wr_ptr} == (len_q - len_t'(1)));

    assign inc       = grp_beat && !eff_last;
    assign underflow = calc_out_partial_valid && (pend == 2'd0);
    assign wr_en     = calc_out_partial_valid && (pend != 2'd0);

    // State register.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (mac_valid && eff_last && rd_wrap) state_nxt = DRAIN;
            DRAIN:   if ((pend == 2'd0) && !valid_q) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pointers, stripe flags, outstanding count and sticky error.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            len_q   <= LEN_MIN;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            pend    <= '0;
            err_q   <= 1'b0;
        end else begin
            if (start) begin
                len_q <= len_cfg;
            end
            if (grp_beat) begin
                rd_ptr <= rd_wrap ? '0 : rd_ptr + 1'b1;
            end
            if (grp_beat && at_zero) begin
                first_q <= mac_first;
                last_q  <= mac_last;
            end
            // Write-backs return in issue order, so wrapping keeps wr_ptr
            // aligned to element 0 at every non-final stripe boundary.
            if (start) begin
                wr_ptr <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_wrap ? '0 : wr_ptr + 1'b1;
            end
            unique case ({inc, wr_en})
                2'b10:   pend <= pend + 2'd1;
                2'b01:   pend <= pend - 2'd1;
                default: pend <= pend;
            endcase
            if ((start && len_bad) || underflow || idle_stray) begin
                err_q <= 1'b1;
            end
        end
    end

    // Forward-path register stage, aligned with the RAM read data.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            opv_q   <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            valid_q <= issue;
            if (issue) begin
                data_q <= mac_data;
            end
            opv_q <= grp_beat && !eff_first;
            sel_q <= grp_beat && eff_last;
        end
    end

    nv_nvdla_cacc_psum_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (CACC_PW)
    ) u_ram (
        .clk   (nvdla_core_clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (calc_out_partial_data),
        .re    (grp_beat),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign calc_in_valid    = valid_q;
    assign calc_in_data     = data_q;
    assign calc_in_op_valid = opv_q;
    assign calc_in_sel      = sel_q;
    assign calc_in_op       = opv_q ? rd_data : '0;
    assign busy             = (state != IDLE);
    assign err              = err_q;

endmodule

// File: tb/tb_nv_nvdla_cacc_psum_buf.sv
// Directed bench for nv_nvdla_cacc_psum_buf with a fixed-latency calculator model.
module tb_nv_nvdla_cacc_psum_buf;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 6;

    logic        nvdla_core_clk  = 1'b0;
    logic        nvdla_core_rstn = 1'b1;
    logic [AW:0] cfg_stripe_len  = 7'd4;
    logic        mac_valid = 1'b0;
    logic [21:0] mac_data  = '0;
    logic        mac_first = 1'b0;
    logic        mac_last  = 1'b0;
    logic        calc_in_valid;
    logic [21:0] calc_in_data;
    logic [33:0] calc_in_op;
    logic        calc_in_op_valid;
    logic        calc_in_sel;
    logic        calc_out_partial_valid;
    logic [33:0] calc_out_partial_data;
    logic        busy;
    logic        err;

    logic        model_pv = 1'b0;
    logic [33:0] model_pd = '0;
    logic        inj_pv   = 1'b0;
    logic [33:0] inj_pd   = '0;
    logic        s1v = 1'b0, s2v = 1'b0;
    logic [33:0] s1d = '0, s2d = '0;

    int vectors     = 0;
    int miscompares = 0;
    int partials    = 0;

    assign calc_out_partial_valid = model_pv | inj_pv;
    assign calc_out_partial_data  = inj_pv ? inj_pd : model_pd;

    nv_nvdla_cacc_psum_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .nvdla_core_clk         (nvdla_core_clk),
        .nvdla_core_rstn        (nvdla_core_rstn),
        .cfg_stripe_len         (cfg_stripe_len),
        .mac_valid              (mac_valid),
        .mac_data               (mac_data),
        .mac_first              (mac_first),
        .mac_last               (mac_last),
        .calc_in_valid          (calc_in_valid),
        .calc_in_data           (calc_in_data),
        .calc_in_op             (calc_in_op),
        .calc_in_op_valid       (calc_in_op_valid),
        .calc_in_sel            (calc_in_sel),
        .calc_out_partial_valid (calc_out_partial_valid),
        .calc_out_partial_data  (calc_out_partial_data),
        .busy                   (busy),
        .err                    (err)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    // Calculator: partial = op + sext(data), returned two cycles after it is
    // presented (three after the MAC beat), only for non-final beats.
    initial begin : calc_model
        forever begin
            @(negedge nvdla_core_clk);
            if (!nvdla_core_rstn) begin
                s1v = 1'b0;
                s2v = 1'b0;
                model_pv = 1'b0;
            end else begin
                model_pv = s2v;
                model_pd = s2d;
                s2v = s1v;
                s2d = s1d;
                s1v = calc_in_valid && !calc_in_sel;
                s1d = (calc_in_op_valid ? calc_in_op : 34'd0)
                      + {{12{calc_in_data[21]}}, calc_in_data};
                if (s1v) partials++;
            end
        end
    end

    task automatic drive(input logic v, input logic [21:0] d, input logic f, input logic l);
        @(negedge nvdla_core_clk);
        mac_valid = v;
        mac_data  = d;
        mac_first = f;
        mac_last  = l;
        @(posedge nvdla_core_clk);
        #1;
    endtask

    task automatic wait_idle(output int unsigned cycles);
        cycles = 0;
        while (busy && cycles < 40) begin
            drive(1'b0, 22'd0, 1'b0, 1'b0);
            cycles++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b0;
        mac_valid = 1'b0;
        @(negedge nvdla_core_clk);
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b1;
    endtask

    task automatic test_reset();
        logic [60:0] got;
        #2 nvdla_core_rstn = 1'b0;
        #1;
        got = {calc_in_valid, calc_in_op_valid, calc_in_sel, busy, err, calc_in_data, calc_in_op};
        vectors++;
        if (got !== 61'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected %h", got, 61'd0);
        end
        @(negedge nvdla_core_clk);
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b1;
        drive(1'b0, 22'd0, 1'b0, 1'b0);
        vectors++;
        if ({busy, err, calc_in_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_release: got %b expected 000", {busy, err, calc_in_valid});
        end
    endtask

    task automatic test_single_stripe();
        logic [58:0] got, exp;
        int unsigned cycles;
        int p0;
        p0 = partials;
        for (int unsigned i = 0; i < 4; i++) begin
            drive(1'b1, 22'(i + 1), 1'b1, 1'b1);
            got = {calc_in_valid, calc_in_op_valid, calc_in_sel, calc_in_data, calc_in_op};
            exp = {1'b1, 1'b0, 1'b1, 22'(i + 1), 34'd0};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL single[%0d]: got %h expected %h", i, got, exp);
            end
        end
        wait_idle(cycles);
        vectors++;
        if (busy !== 1'b0 || cycles != 2) begin
            miscompares++;
            $display("FAIL single_busy_fall: got busy=%b after %0d cycles expected busy=0 after 2", busy, cycles);
        end
        vectors++;
        if (partials - p0 != 0) begin
            miscompares++;
            $display("FAIL single_no_writes: got %0d partials expected 0", partials - p0);
        end
    endtask

    task automatic test_three_stripe();
        logic [58:0] got, exp;
        int unsigned cycles;
        int p0;
        p0 = partials;
        for (int unsigned s = 0; s < 3; s++) begin
            for (int unsigned e = 0; e < 4; e++) begin
                drive(1'b1, 22'd10, s == 0, s == 2);
                got = {calc_in_valid, calc_in_op_valid, calc_in_sel, calc_in_data, calc_in_op};
                exp = {1'b1, s != 0, s == 2, 22'd10, 34'(s * 10)};
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL three[%0d][%0d]: got %h expected %h", s, e, got, exp);
                end
            end
        end
        wait_idle(cycles);
        vectors++;
        if (busy !== 1'b0 || partials - p0 != 8) begin
            miscompares++;
            $display("FAIL three_drain: got busy=%b partials=%0d expected busy=0 partials=8", busy, partials - p0);
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] d0 [4] = '{22'd5, 22'd6, 22'd7, 22'd8};
        logic [21:0] d1 [4] = '{-22'sd1, 22'd3, -22'sd10, 22'd100};
        logic [33:0] o2 [4] = '{34'd4, 34'd9, -34'sd3, 34'd108};
        logic [58:0] got, exp;
        int unsigned cycles;
        for (int unsigned s = 0; s < 3; s++) begin
            for (int unsigned e = 0; e < 4; e++) begin
                if (s == 0) begin
                    drive(1'b1, d0[e], 1'b1, 1'b0);
                    exp = {1'b1, 1'b0, 1'b0, d0[e], 34'd0};
                end else if (s == 1) begin
                    drive(1'b1, d1[e], 1'b0, 1'b0);
                    exp = {1'b1, 1'b1, 1'b0, d1[e], 34'(d0[e])};
                end else begin
                    drive(1'b1, 22'd0, 1'b0, 1'b1);
                    exp = {1'b1, 1'b1, 1'b1, 22'd0, o2[e]};
                end
                got = {calc_in_valid, calc_in_op_valid, calc_in_sel, calc_in_data, calc_in_op};
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL b2b[%0d][%0d]: got %h expected %h", s, e, got, exp);
                end
            end
        end
        wait_idle(cycles);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_wrap();
        logic [58:0] got, exp;
        int unsigned cycles, gaps;
        cfg_stripe_len = 7'd64;
        for (int unsigned s = 0; s < 3; s++) begin
            for (int unsigned e = 0; e < 64; e++) begin
                if (s == 0) begin
                    drive(1'b1, 22'(e + 1), 1'b1, 1'b0);
                    exp = {1'b1, 1'b0, 1'b0, 22'(e + 1), 34'd0};
                end else if (s == 1) begin
                    drive(1'b1, 22'd100, 1'b0, 1'b0);
                    exp = {1'b1, 1'b1, 1'b0, 22'd100, 34'(e + 1)};
                end else begin
                    drive(1'b1, 22'd0, 1'b0, 1'b1);
                    exp = {1'b1, 1'b1, 1'b1, 22'd0, 34'(e + 101)};
                end
                got = {calc_in_valid, calc_in_op_valid, calc_in_sel, calc_in_data, calc_in_op};
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL wrap[%0d][%0d]: got %h expected %h", s, e, got, exp);
                end
                gaps = $urandom_range(2);
                for (int unsigned b = 0; b < gaps; b++) begin
                    drive(1'b0, 22'd0, 1'b0, 1'b0);
                    vectors++;
                    if (calc_in_valid !== 1'b0) begin
                        miscompares++;
                        $display("FAIL wrap_bubble[%0d][%0d]: got valid=%b expected 0", s, e, calc_in_valid);
                    end
                end
            end
        end
        wait_idle(cycles);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_idle: got busy=%b expected 0", busy);
        end
        cfg_stripe_len = 7'd4;
    endtask

    task automatic test_underflow();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL underflow_pre: got err=%b expected 0", err);
        end
        @(negedge nvdla_core_clk);
        inj_pv = 1'b1;
        inj_pd = 34'h1234;
        @(posedge nvdla_core_clk);
        #1;
        inj_pv = 1'b0;
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow_set: got err=%b expected 1", err);
        end
        for (int unsigned i = 0; i < 5; i++) drive(1'b0, 22'd0, 1'b0, 1'b0);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow_sticky: got err=%b expected 1", err);
        end
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b0;
        #1;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL underflow_reset_clear: got err=%b expected 0", err);
        end
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b1;
    endtask

    task automatic test_bad_len();
        logic [21:0] d [4] = '{22'd11, 22'd22, 22'd33, 22'd44};
        logic [58:0] got, exp;
        int unsigned cycles;
        cfg_stripe_len = 7'd2;
        for (int unsigned s = 0; s < 2; s++) begin
            for (int unsigned e = 0; e < 4; e++) begin
                if (s == 0) begin
                    drive(1'b1, d[e], 1'b1, 1'b0);
                    exp = {1'b1, 1'b0, 1'b0, d[e], 34'd0};
                end else begin
                    drive(1'b1, 22'd0, 1'b0, 1'b1);
                    exp = {1'b1, 1'b1, 1'b1, 22'd0, 34'(d[e])};
                end
                got = {calc_in_valid, calc_in_op_valid, calc_in_sel, calc_in_data, calc_in_op};
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL badlen[%0d][%0d]: got %h expected %h", s, e, got, exp);
                end
                if (s == 0 && e == 0) begin
                    vectors++;
                    if (err !== 1'b1) begin
                        miscompares++;
                        $display("FAIL badlen_err: got err=%b expected 1", err);
                    end
                end
            end
        end
        wait_idle(cycles);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL badlen_idle: got busy=%b expected 0", busy);
        end
        cfg_stripe_len = 7'd4;
    endtask

    task automatic test_mid_reset();
        logic [58:0] got, exp;
        logic [60:0] all;
        int unsigned cycles;
        for (int unsigned e = 0; e < 4; e++) drive(1'b1, 22'd7, 1'b1, 1'b0);
        drive(1'b1, 22'd7, 1'b0, 1'b0);
        drive(1'b1, 22'd7, 1'b0, 1'b0);
        vectors++;
        if ({calc_in_valid, calc_in_op_valid, calc_in_op} !== {2'b11, 34'd7}) begin
            miscompares++;
            $display("FAIL midrst_pre: got %h expected %h",
                     {calc_in_valid, calc_in_op_valid, calc_in_op}, {2'b11, 34'd7});
        end
        nvdla_core_rstn = 1'b0;
        mac_valid = 1'b0;
        #1;
        all = {calc_in_valid, calc_in_op_valid, calc_in_sel, busy, err, calc_in_data, calc_in_op};
        vectors++;
        if (all !== 61'd0) begin
            miscompares++;
            $display("FAIL midrst_async: got %h expected %h", all, 61'd0);
        end
        @(negedge nvdla_core_clk);
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b1;
        for (int unsigned e = 0; e < 4; e++) begin
            drive(1'b1, 22'd3, 1'b1, 1'b1);
            got = {calc_in_valid, calc_in_op_valid, calc_in_sel, calc_in_data, calc_in_op};
            exp = {1'b1, 1'b0, 1'b1, 22'd3, 34'd0};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL midrst_new[%0d]: got %h expected %h", e, got, exp);
            end
        end
        wait_idle(cycles);
        vectors++;
        if ({busy, err} !== 2'b00) begin
            miscompares++;
            $display("FAIL midrst_idle: got busy/err=%b expected 00", {busy, err});
        end
    endtask

    initial begin
        test_reset();
        test_single_stripe();
        test_three_stripe();
        test_back_to_back();
        test_wrap();
        test_underflow();
        test_bad_len();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
